// File: rtl/array_4_fifo_ctrl.sv
// Valid/ready FIFO controller for the array_4_ext single-port SRAM with a 2-entry output buffer.
// Optional empty-queue bypass into the output buffer: define ARRAY_FIFO_BYPASS_EN.
module array_4_fifo_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [DW-1:0] enq_bits,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [DW-1:0] deq_bits,
    output logic [AW+1:0] count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    output logic          mem_wmode,
    output logic [DW-1:0] mem_wmask,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic          ob_head_q, ob_head_d;
    logic [DW-1:0] ob_mem_q [2];

    logic [2:0]    ob_occ;
    logic          rd_want;
    logic          enq_fire;
    logic          bypass;
    logic          rd_issue;
    logic          wr_issue;
    logic          ob_push;
    logic          ob_pop;
    logic          ob_widx;
    logic [DW-1:0] ob_push_data;

    // Port arbitration depends only on registered state, so enq_ready never sees enq_valid/deq_ready.
    always_comb begin
        ob_occ    = 3'(ob_cnt_q) + 3'(rd_inflight_q);
        rd_want   = (ram_cnt_q != '0) && (ob_occ < 3'd2);
        enq_ready = reset_n && !rd_want && (ram_cnt_q < DEPTH_C);
        enq_fire  = enq_valid && enq_ready;
`ifdef ARRAY_FIFO_BYPASS_EN
        bypass    = enq_fire && (ram_cnt_q == '0) && !rd_inflight_q && (ob_cnt_q != 2'd2);
`else
        bypass    = 1'b0;
`endif
        rd_issue  = reset_n && rd_want;
        wr_issue  = enq_fire && !bypass;

        mem_en    = rd_issue || wr_issue;
        mem_wmode = wr_issue;
        mem_addr  = rd_issue ? rd_ptr_q : wr_ptr_q;
        mem_wdata = enq_bits;
        mem_wmask = '1;
    end

    // Output buffer: a returning read and a bypass write are mutually exclusive sources.
    always_comb begin
        ob_push      = rd_inflight_q || bypass;
        ob_push_data = rd_inflight_q ? mem_rdata : enq_bits;
        deq_valid    = (ob_cnt_q != 2'd0);
        deq_bits     = ob_mem_q[ob_head_q];
        ob_pop       = deq_valid && deq_ready;
        ob_widx      = ob_head_q ^ ob_cnt_q[0];
        count        = (AW+2)'(ram_cnt_q) + (AW+2)'(rd_inflight_q) + (AW+2)'(ob_cnt_q);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q - (AW+1)'(1);
        end else if (wr_issue) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q + (AW+1)'(1);
        end
        rd_inflight_d = rd_issue;
        ob_head_d     = ob_head_q ^ ob_pop;
        ob_cnt_d      = ob_cnt_q + 2'(ob_push) - 2'(ob_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= 2'd0;
            ob_head_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob_cnt_q      <= ob_cnt_d;
            ob_head_q     <= ob_head_d;
        end
    end

    // Buffer storage is never reset; ob_cnt_q alone defines which slots hold live data.
    always_ff @(posedge clock) begin
        if (ob_push) begin
            ob_mem_q[ob_widx] <= ob_push_data;
        end
    end

endmodule
